// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states, select codes
// and the packed control bundle that the decoder hands to the top.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [5:0] alu_funct;
        logic       imm_zero_ext;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                               return S_MEM_ADDR;
            OP_RTYPE:                                   return S_R_EXEC;
            OP_BEQ:                                     return S_BRANCH;
            OP_J:                                       return S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  return S_I_EXEC;
            default:                                    return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purpose: combinational map from FSM state (plus opcode/funct/mem_ready) to the control bundle.
// Latency: zero cycles, pure combinational.
// Backpressure: mem_ready only gates the FETCH and MEM_WRITE completion strobes.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
                ctrl.alu_funct = funct;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                // The ALU control decoder matches I-type opcodes on its function input.
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_IMM;
                ctrl.alu_op       = ALUOP_ITYPE;
                ctrl.alu_funct    = opcode;
                ctrl.imm_zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Purpose: main control FSM of the multi-cycle MIPS datapath; state register, sequencing, reset gating.
// Latency: R/I/sw 4 cycles, lw 5, beq/j/illegal 3, plus one per memory cycle without mem_ready.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold with mem_req asserted until mem_ready.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [5:0] alu_funct,
    output logic       imm_zero_ext,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = decode_target(opcode);
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .funct     (funct),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Reset kills every enable combinationally so an in-flight access is abandoned in the same cycle.
    assign mem_req       = ctrl.mem_req       & ~reset;
    assign mem_we        = ctrl.mem_we        & ~reset;
    assign ir_write      = ctrl.ir_write      & ~reset;
    assign pc_write      = ctrl.pc_write      & ~reset;
    assign pc_write_cond = ctrl.pc_write_cond & ~reset;
    assign reg_write     = ctrl.reg_write     & ~reset;
    assign instr_done    = ctrl.instr_done    & ~reset;
    assign illegal_op    = ctrl.illegal_op    & ~reset;

    assign i_or_d       = ctrl.i_or_d;
    assign pc_source    = ctrl.pc_source;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_op       = ctrl.alu_op;
    assign alu_funct    = ctrl.alu_funct;
    assign imm_zero_ext = ctrl.imm_zero_ext;
    assign reg_dst      = ctrl.reg_dst;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign state        = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed path table, corner sequences, randomized instruction stream.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, imm_zero_ext, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
    logic [5:0] alu_funct;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .alu_funct(alu_funct),
        .imm_zero_ext(imm_zero_ext), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour, including the mem_ready value to drive in that cycle.
    typedef struct packed {
        logic       rdy;
        logic [3:0] st;
        logic       mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, instr_done, illegal_op;
        logic       i_or_d;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [5:0] alu_funct;
        logic       imm_zero_ext, reg_dst, mem_to_reg;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c = '0;
        c.st = st;
        c.rdy = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Reference model: expand one instruction into its cycle-by-cycle expected trace.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms);
        cyc_t c;
        for (int i = 0; i <= fs; i++) begin
            c = blank(4'd0);
            c.rdy = (i == fs);
            c.mem_req = 1'b1; c.alu_src_b = 2'b01;
            c.ir_write = c.rdy; c.pc_write = c.rdy;
            exp_q.push_back(c);
        end
        c = blank(4'd1); c.alu_src_b = 2'b11; exp_q.push_back(c);
        case (op)
            6'b100011, 6'b101011: begin
                c = blank(4'd2); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; exp_q.push_back(c);
                for (int i = 0; i <= ms; i++) begin
                    c = blank(op == 6'b100011 ? 4'd3 : 4'd5);
                    c.rdy = (i == ms);
                    c.mem_req = 1'b1; c.i_or_d = 1'b1;
                    c.mem_we = (op == 6'b101011);
                    c.instr_done = (op == 6'b101011) && c.rdy;
                    exp_q.push_back(c);
                end
                if (op == 6'b100011) begin
                    c = blank(4'd4); c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
                    exp_q.push_back(c);
                end
            end
            6'b000000: begin
                c = blank(4'd6); c.alu_src_a = 1'b1; c.alu_op = 2'b10; c.alu_funct = fn; exp_q.push_back(c);
                c = blank(4'd7); c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
            end
            6'b000100: begin
                c = blank(4'd8); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.instr_done = 1'b1; exp_q.push_back(c);
            end
            6'b000010: begin
                c = blank(4'd9); c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; exp_q.push_back(c);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                c = blank(4'd10); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.alu_funct = op;
                c.imm_zero_ext = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
                exp_q.push_back(c);
                c = blank(4'd11); c.reg_write = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
            end
            default: begin
                c = blank(4'd12); c.illegal_op = 1'b1; c.instr_done = 1'b1; exp_q.push_back(c);
            end
        endcase
    endtask

    task automatic run_model(input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        opcode = op; funct = fn;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            mem_ready = c.rdy;
            @(negedge clk);
            check("rnd_state", 32'(state), 32'(c.st));
            check("rnd_enables",
                  32'({mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, instr_done, illegal_op}),
                  32'({c.mem_req, c.mem_we, c.ir_write, c.pc_write, c.pc_write_cond, c.reg_write, c.instr_done, c.illegal_op}));
            check("rnd_selects",
                  32'({i_or_d, pc_source, alu_src_a, alu_src_b, alu_op, alu_funct, imm_zero_ext, reg_dst, mem_to_reg}),
                  32'({c.i_or_d, c.pc_source, c.alu_src_a, c.alu_src_b, c.alu_op, c.alu_funct, c.imm_zero_ext, c.reg_dst, c.mem_to_reg}));
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        int          fs;
        int          ms;
        int          len;
        logic [47:0] path;   // expected states, first cycle in the top nibble
    } vec_t;

    vec_t tbl[9];

    logic [5:0] legal_ops[10];
    logic [5:0] bad_ops[4];

    initial begin
        tbl[0] = '{6'b000000, 6'b100000, 0, 0, 4, 48'h0167_0000_0000};
        tbl[1] = '{6'b100011, 6'b000000, 0, 3, 8, 48'h0123_3334_0000};
        tbl[2] = '{6'b101011, 6'b000000, 1, 0, 5, 48'h0012_5000_0000};
        tbl[3] = '{6'b000100, 6'b000000, 0, 0, 3, 48'h0180_0000_0000};
        tbl[4] = '{6'b000010, 6'b000000, 0, 0, 3, 48'h0190_0000_0000};
        tbl[5] = '{6'b001101, 6'b000000, 0, 0, 4, 48'h01AB_0000_0000};
        tbl[6] = '{6'b111111, 6'b000000, 0, 0, 3, 48'h01C0_0000_0000};
        tbl[7] = '{6'b100011, 6'b000000, 2, 0, 7, 48'h0001_2340_0000};
        tbl[8] = '{6'b101011, 6'b000000, 0, 2, 6, 48'h0125_5500_0000};
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
        bad_ops = '{6'b111111, 6'b000011, 6'b100000, 6'b010000};

        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("reset_state", 32'(state), 32'd0);
            check("reset_enables",
                  32'({mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, instr_done, illegal_op}), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed path table; mem_ready is withheld for the listed number of memory cycles.
        for (int v = 0; v < 9; v++) begin
            int n, fcnt, mcnt, dones, illegals;
            bit done;
            opcode = tbl[v].op; funct = tbl[v].fn;
            n = 0; fcnt = 0; mcnt = 0; dones = 0; illegals = 0; done = 0;
            while (!done && n < 16) begin
                if (state == 4'd0) begin
                    mem_ready = (fcnt >= tbl[v].fs);
                    if (!mem_ready) fcnt++;
                end else if (state == 4'd3 || state == 4'd5) begin
                    mem_ready = (mcnt >= tbl[v].ms);
                    if (!mem_ready) mcnt++;
                end else begin
                    mem_ready = 1'b0;
                end
                @(negedge clk);
                if (n < tbl[v].len) check($sformatf("tbl%0d_state%0d", v, n), 32'(state), 32'(tbl[v].path[47 - 4*n -: 4]));
                if (instr_done) begin dones++; done = 1; end
                if (illegal_op) illegals++;
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("tbl%0d_len", v), 32'(n), 32'(tbl[v].len));
            check($sformatf("tbl%0d_illegal", v), 32'(illegals), (tbl[v].op == 6'b111111) ? 32'd1 : 32'd0);
            check($sformatf("tbl%0d_back_to_fetch", v), 32'(state), 32'd0);
        end

        // Reset during a stalled store: enables drop in the same cycle, FSM restarts at FETCH.
        opcode = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_stall_state", 32'(state), 32'd5);
        check("sw_stall_req", 32'({mem_req, mem_we, i_or_d}), 32'b111);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_req", 32'({mem_req, mem_we, instr_done, reg_write}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_state", 32'(state), 32'd0);

        // Directed trace checks for the immediate and branch/jump corner cases.
        model_instr(6'b001101, 6'b000000, 0, 0); run_model(6'b001101, 6'b000000);
        model_instr(6'b001000, 6'b000000, 1, 0); run_model(6'b001000, 6'b000000);
        model_instr(6'b000100, 6'b000000, 0, 0); run_model(6'b000100, 6'b000000);
        model_instr(6'b000010, 6'b000000, 0, 0); run_model(6'b000010, 6'b000000);

        // Randomized instruction stream with random memory stalls and random mem_ready elsewhere.
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op, fn;
            int pick;
            pick = $urandom_range(0, 11);
            op = (pick < 10) ? legal_ops[pick] : bad_ops[$urandom_range(0, 3)];
            fn = 6'($urandom_range(0, 63));
            model_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
            run_model(op, fn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
